// File: rtl/trdb_trigger.sv
// trdb_trigger: address-match trigger unit feeding the trace register block.
// Watches retired instructions and issues one-cycle trace on/off requests when
// the (hit-count qualified) start and stop addresses are seen.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cfg_en_i              trigger enable (0 forces IDLE)
//   cfg_rearm_i           1: back to ARMED after stop, 0: go to DONE
//   cfg_start_addr_i      start match address   (latched on arm/rearm)
//   cfg_stop_addr_i       stop match address    (latched on arm/rearm)
//   cfg_start_cnt_i       start hits required, 0 means 1 (latched)
//   cfg_stop_cnt_i        stop hits required, 0 means 1 (latched)
//   iretire_i, iaddr_i    retired-instruction strobe and address
//   trace_req_on_o        one-cycle registered request to start tracing
//   trace_req_off_o       one-cycle registered request to stop tracing
//   tracing_o             high while in TRACING
//   state_o               IDLE=0, ARMED=1, TRACING=2, DONE=3
module trdb_trigger #(
    parameter int XLEN      = 32,
    parameter int HIT_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_en_i,
    input  logic                 cfg_rearm_i,
    input  logic [XLEN-1:0]      cfg_start_addr_i,
    input  logic [XLEN-1:0]      cfg_stop_addr_i,
    input  logic [HIT_CNT_W-1:0] cfg_start_cnt_i,
    input  logic [HIT_CNT_W-1:0] cfg_stop_cnt_i,
    input  logic                 iretire_i,
    input  logic [XLEN-1:0]      iaddr_i,
    output logic                 trace_req_on_o,
    output logic                 trace_req_off_o,
    output logic                 tracing_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        TRACING = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int CW = HIT_CNT_W + 1;

    state_t                 state;
    logic [HIT_CNT_W-1:0]   hit_cnt;
    logic [XLEN-1:0]        start_addr;
    logic [XLEN-1:0]        stop_addr;
    logic [HIT_CNT_W-1:0]   start_cnt;
    logic [HIT_CNT_W-1:0]   stop_cnt;

    logic                   start_hit;
    logic                   stop_hit;
    logic [CW-1:0]          hit_next;
    logic [CW-1:0]          eff_start;
    logic [CW-1:0]          eff_stop;
    logic                   start_final;
    logic                   stop_final;

    assign start_hit = iretire_i && (iaddr_i == start_addr);
    assign stop_hit  = iretire_i && (iaddr_i == stop_addr);

    // Compare one bit wider than the counter so hit_cnt+1 cannot wrap.
    assign hit_next  = {1'b0, hit_cnt} + CW'(1);
    assign eff_start = (start_cnt == '0) ? CW'(1) : {1'b0, start_cnt};
    assign eff_stop  = (stop_cnt  == '0) ? CW'(1) : {1'b0, stop_cnt};
    assign start_final = (hit_next == eff_start);
    assign stop_final  = (hit_next == eff_stop);

    assign state_o = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            hit_cnt         <= '0;
            start_addr      <= '0;
            stop_addr       <= '0;
            start_cnt       <= '0;
            stop_cnt        <= '0;
            trace_req_on_o  <= 1'b0;
            trace_req_off_o <= 1'b0;
            tracing_o       <= 1'b0;
        end else begin
            trace_req_on_o  <= 1'b0;
            trace_req_off_o <= 1'b0;
            if (!cfg_en_i) begin
                // Disable wins over any same-cycle match; close an open
                // trace window so downstream is never left enabled.
                state           <= IDLE;
                hit_cnt         <= '0;
                tracing_o       <= 1'b0;
                trace_req_off_o <= (state == TRACING);
            end else begin
                case (state)
                    IDLE: begin
                        state      <= ARMED;
                        hit_cnt    <= '0;
                        start_addr <= cfg_start_addr_i;
                        stop_addr  <= cfg_stop_addr_i;
                        start_cnt  <= cfg_start_cnt_i;
                        stop_cnt   <= cfg_stop_cnt_i;
                    end
                    ARMED: begin
                        if (start_hit) begin
                            if (start_final) begin
                                state          <= TRACING;
                                hit_cnt        <= '0;
                                trace_req_on_o <= 1'b1;
                                tracing_o      <= 1'b1;
                            end else begin
                                hit_cnt <= hit_cnt + 1'b1;
                            end
                        end
                    end
                    TRACING: begin
                        // Only evaluated from the cycle after the start fired,
                        // so the start retirement never counts as a stop hit.
                        if (stop_hit) begin
                            if (stop_final) begin
                                hit_cnt         <= '0;
                                trace_req_off_o <= 1'b1;
                                tracing_o       <= 1'b0;
                                if (cfg_rearm_i) begin
                                    state      <= ARMED;
                                    start_addr <= cfg_start_addr_i;
                                    stop_addr  <= cfg_stop_addr_i;
                                    start_cnt  <= cfg_start_cnt_i;
                                    stop_cnt   <= cfg_stop_cnt_i;
                                end else begin
                                    state <= DONE;
                                end
                            end else begin
                                hit_cnt <= hit_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= DONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trdb_trigger.sv
// Directed testbench for trdb_trigger with hand-computed expectations.
module tb_trdb_trigger;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_en;
    logic        cfg_rearm;
    logic [31:0] cfg_start_addr;
    logic [31:0] cfg_stop_addr;
    logic [7:0]  cfg_start_cnt;
    logic [7:0]  cfg_stop_cnt;
    logic        iretire;
    logic [31:0] iaddr;
    logic        trace_req_on;
    logic        trace_req_off;
    logic        tracing;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    trdb_trigger #(.XLEN(32), .HIT_CNT_W(8)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cfg_en_i         (cfg_en),
        .cfg_rearm_i      (cfg_rearm),
        .cfg_start_addr_i (cfg_start_addr),
        .cfg_stop_addr_i  (cfg_stop_addr),
        .cfg_start_cnt_i  (cfg_start_cnt),
        .cfg_stop_cnt_i   (cfg_stop_cnt),
        .iretire_i        (iretire),
        .iaddr_i          (iaddr),
        .trace_req_on_o   (trace_req_on),
        .trace_req_off_o  (trace_req_off),
        .tracing_o        (tracing),
        .state_o          (state)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Outputs as {on, off, tracing, state}
    function automatic logic [4:0] outs();
        return {trace_req_on, trace_req_off, tracing, state};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] a);
        iretire = 1'b1;
        iaddr   = a;
        step();
        iretire = 1'b0;
        iaddr   = '0;
    endtask

    initial begin
        rst = 1'b1; cfg_en = 1'b0; cfg_rearm = 1'b0;
        cfg_start_addr = 32'h100; cfg_stop_addr = 32'h200;
        cfg_start_cnt = 8'd0; cfg_stop_cnt = 8'd0;
        iretire = 1'b0; iaddr = '0;
        step(); step();
        chk("reset_outs", 32'(outs()), 32'b00000);
        rst = 1'b0;

        // 1: basic one-shot
        cfg_en = 1'b1;
        step();
        chk("t1_armed", 32'(outs()), 32'b00001);
        retire(32'h100);
        chk("t1_on", 32'(outs()), 32'b10110);
        step();
        chk("t1_on_1cyc", 32'(outs()), 32'b00110);
        retire(32'h200);
        chk("t1_off", 32'(outs()), 32'b01011);
        step();
        chk("t1_done_hold", 32'(outs()), 32'b00011);

        // 2: start count 3 with gaps
        cfg_en = 1'b0; step();
        chk("t2_idle", 32'(outs()), 32'b00000);
        cfg_start_cnt = 8'd3; cfg_en = 1'b1; step();
        retire(32'h100);
        chk("t2_hit1", 32'(outs()), 32'b00001);
        step(); step();
        retire(32'h100);
        chk("t2_hit2", 32'(outs()), 32'b00001);
        step();
        retire(32'h100);
        chk("t2_hit3_on", 32'(outs()), 32'b10110);
        retire(32'h200);
        chk("t2_off", 32'(outs()), 32'b01011);

        // 3: start==stop, rearm
        cfg_en = 1'b0; step();
        cfg_start_addr = 32'h400; cfg_stop_addr = 32'h400;
        cfg_start_cnt = 8'd0; cfg_rearm = 1'b1; cfg_en = 1'b1; step();
        chk("t3_armed", 32'(outs()), 32'b00001);
        retire(32'h400);
        chk("t3_on", 32'(outs()), 32'b10110);
        retire(32'h400);
        chk("t3_off_rearm", 32'(outs()), 32'b01001);
        retire(32'h400);
        chk("t3_on_again", 32'(outs()), 32'b10110);

        // 4: disable while tracing, then disable beats a start hit
        cfg_start_addr = 32'h100; cfg_stop_addr = 32'h200; cfg_rearm = 1'b0;
        cfg_en = 1'b0; step();
        chk("t4_dis_off", 32'(outs()), 32'b01000);
        step();
        chk("t4_off_1cyc", 32'(outs()), 32'b00000);
        cfg_en = 1'b1; step();
        chk("t4_armed", 32'(outs()), 32'b00001);
        cfg_en = 1'b0;
        retire(32'h100);
        chk("t4_dis_prio", 32'(outs()), 32'b00000);

        // 5: cfg change while ARMED is ignored; stop count 2
        cfg_stop_cnt = 8'd2;
        cfg_en = 1'b1; step();
        cfg_start_addr = 32'h300;
        retire(32'h300);
        chk("t5_no_relatch", 32'(outs()), 32'b00001);
        retire(32'h100);
        chk("t5_on", 32'(outs()), 32'b10110);
        retire(32'h200);
        chk("t5_stop1", 32'(outs()), 32'b00110);

        // 6: async reset with stop hit in flight
        iretire = 1'b1; iaddr = 32'h200;
        rst = 1'b1;
        #1;
        chk("t6_async_rst", 32'(outs()), 32'b00000);
        @(posedge clk); #1;
        iretire = 1'b0; iaddr = '0;
        rst = 1'b0;
        chk("t6_in_rst", 32'(outs()), 32'b00000);
        step();
        chk("t6_release", 32'(outs()), 32'b00001);
        step();
        chk("t6_no_pulse", 32'(outs()), 32'b00001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/trdb_trigger.md
Name: trdb_trigger

Overview:
- Address-match trigger unit directly upstream of the trace register block.
- Watches the retired-instruction stream and generates the single-cycle trace_req_on_o / trace_req_off_o requests consumed by the register block's edge detectors.
- Start and stop conditions are address matches, each qualified by a programmable hit count.
- Operates one-shot or auto-rearm.

Parameters:
XLEN, 32, instruction address width
HIT_CNT_W, 8, width of start/stop hit counters and count configuration

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous reset, active-high
cfg_en_i  input  1  trigger enable; 0 forces IDLE
cfg_rearm_i  input  1  1: return to ARMED after stop fires; 0: go to DONE
cfg_start_addr_i  input  XLEN  start-trigger match address
cfg_stop_addr_i  input  XLEN  stop-trigger match address
cfg_start_cnt_i  input  HIT_CNT_W  start matches required (0 treated as 1)
cfg_stop_cnt_i  input  HIT_CNT_W  stop matches required (0 treated as 1)
iretire_i  input  1  one instruction retired this cycle
iaddr_i  input  XLEN  address of retired instruction, valid with iretire_i
trace_req_on_o  output  1  one-cycle pulse: request tracing on
trace_req_off_o  output  1  one-cycle pulse: request tracing off
tracing_o  output  1  high while state is TRACING
state_o  output  2  current state: IDLE=0, ARMED=1, TRACING=2, DONE=3

Behaviour:
- Reset, asynchronous, rst_i=1:
  - state IDLE, hit counter 0, latched config 0.
  - All outputs 0.
- Configuration latch:
  - Start/stop addresses and counts are latched on the IDLE->ARMED transition and on every rearm.
  - cfg_* changes at any other time have no effect until the next latch.
- Match definitions:
  - start_hit = iretire_i && iaddr_i == latched start address.
  - stop_hit = iretire_i && iaddr_i == latched stop address.
  - Full XLEN equality.
- Effective count:
  - eff = (cnt == 0) ? 1 : cnt.
  - Comparison is hit_cnt + 1 == eff, evaluated at HIT_CNT_W+1 bits; no wrap.
- IDLE:
  - cfg_en_i=1 -> ARMED next cycle; latch config; hit_cnt=0.
- ARMED:
  - Only start_hit is considered.
  - On start_hit with hit_cnt+1 < eff_start: hit_cnt increments.
  - On start_hit with hit_cnt+1 == eff_start: -> TRACING, hit_cnt=0, trace_req_on_o=1 for exactly the next cycle.
- TRACING:
  - Only stop_hit is considered.
  - The retirement that fired the start is never counted as a stop hit, even if start and stop addresses are equal.
  - On final stop_hit: trace_req_off_o pulses next cycle, hit_cnt=0.
  - Next state is ARMED (re-latch config) if cfg_rearm_i=1, else DONE.
- DONE:
  - Holds; outputs 0.
  - Leaves only via cfg_en_i=0 -> IDLE.
- cfg_en_i=0 in any state:
  - -> IDLE next cycle, hit_cnt=0.
  - If leaving TRACING, trace_req_off_o pulses next cycle, so downstream never remains enabled with the trigger disarmed.
  - cfg_en_i=0 takes priority over a same-cycle match; no trace_req_on_o pulse in that case.
- Latency:
  - Request pulses are registered and appear exactly 1 cycle after the qualifying retirement cycle.
  - trace_req_on_o and trace_req_off_o are never high in the same cycle.
- Pulse spacing: consecutive pulses on the same output are separated by at least one low cycle, as the downstream edge detectors require.
- Status outputs:
  - tracing_o is registered and rises in the same cycle as the trace_req_on_o pulse.
  - tracing_o falls in the same cycle as the trace_req_off_o pulse.
- Counter: hit_cnt never exceeds eff-1. No overflow is possible given the comparison rule.
- Reset mid-operation: immediate IDLE. Any pending pulse is dropped; no off pulse is generated.

Test Plan:
- Start=0x100, stop=0x200, counts 0, rearm=0; retire 0x100 then 0x200 -> on pulse 1 cycle after 0x100, off pulse 1 cycle after 0x200, state_o=3.
- start_cnt=3; retire 0x100 three times with gaps -> no pulse after hits 1–2; on pulse exactly 1 cycle after third hit, hit_cnt back to 0.
- Start=stop=0x400, rearm=1; retire 0x400 twice -> on after first, off after second, state returns ARMED; third 0x400 -> on again.
- In TRACING, drop cfg_en_i -> off pulse next cycle, state IDLE. Same-cycle cfg_en_i=0 with start_hit in ARMED -> no on pulse.
- Change cfg_start_addr_i to 0x300 while ARMED at 0x100; retire 0x300 -> no pulse; retire 0x100 -> on pulse.
- Assert rst_i mid-TRACING with stop hit in flight -> all outputs 0 immediately, state IDLE, no pulse after release.
